// File: rtl/qcs_gpio_event_mon.sv
// GPIO event monitor: per-bit synchronizer and debounce, enabled edge detection,
// per-bit pending slot, lowest-index arbiter and a FWFT event FIFO with drop accounting.
module qcs_gpio_event_mon #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int TS_W            = 16,
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gpio,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   output logic [WIDTH-1:0] gpio_level,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [BW-1:0]    evt_bit,
   output logic             evt_rising,
   output logic [TS_W-1:0]  evt_ts,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic [7:0]       drop_cnt
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = BW + 1 + TS_W;
   localparam logic [CW-1:0] DBC_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_s;
   logic [WIDTH-1:0] stable_q, stable_d, toggle_s, edge_s;
   logic [CW-1:0]    dbc_q [WIDTH];
   logic [CW-1:0]    dbc_d [WIDTH];
   logic [TS_W-1:0]  ts_q;
   logic [WIDTH-1:0] pend_q, pend_d, pdir_q, pdir_d;
   logic [TS_W-1:0]  pts_q [WIDTH];
   logic [TS_W-1:0]  pts_d [WIDTH];
   logic [WIDTH-1:0] grant_s, drop_s;
   logic [BW-1:0]    grant_idx_s;
   logic             push_s, pop_s, can_push_s;
   logic [8:0]       drop_sum_s, drop_tot_s;
   logic [7:0]       drop_cnt_d;
   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [EW-1:0]    wdata_s, head_s;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next_s;
   logic [AW:0]      count_q, count_d, count_kept_s;
   logic             evt_valid_d;

   assign sync_s     = sync_q[SYNC_STAGES-1];
   assign gpio_level = stable_q;
   assign pop_s      = evt_valid & evt_ready;
   assign can_push_s = (count_q != FIFO_FULL) || pop_s;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         stable_d[i] = stable_q[i];
         toggle_s[i] = 1'b0;
         dbc_d[i]    = '0;
         if (sync_s[i] != stable_q[i]) begin
            if (dbc_q[i] == DBC_LAST) begin
               toggle_s[i] = 1'b1;
               stable_d[i] = ~stable_q[i];
            end else begin
               dbc_d[i] = dbc_q[i] + CW'(1);
            end
         end else begin
            dbc_d[i] = '0;
         end
      end
      edge_s = toggle_s & ((~stable_q & rise_en) | (stable_q & fall_en));
   end

   // Descending scan so the lowest pending index wins.
   always_comb begin
      grant_idx_s = '0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (pend_q[i]) begin
            grant_idx_s = BW'(i);
         end else begin
            grant_idx_s = grant_idx_s;
         end
      end
      push_s  = (|pend_q) & can_push_s;
      grant_s = push_s ? (WIDTH'(1) << grant_idx_s) : '0;
      wdata_s = {grant_idx_s, pdir_q[grant_idx_s], pts_q[grant_idx_s]};
   end

   // A slot being pushed this cycle may be reloaded by a fresh edge without a drop.
   always_comb begin
      pend_d     = pend_q & ~grant_s;
      pdir_d     = pdir_q;
      drop_s     = '0;
      drop_sum_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pts_d[i] = pts_q[i];
         if (edge_s[i]) begin
            if (pend_q[i] && !grant_s[i]) begin
               drop_s[i] = 1'b1;
            end else begin
               pend_d[i] = 1'b1;
               pdir_d[i] = ~stable_q[i];
               pts_d[i]  = ts_q;
            end
         end else begin
            pdir_d[i] = pdir_q[i];
         end
         drop_sum_s = drop_sum_s + 9'(drop_s[i]);
      end
      drop_tot_s = {1'b0, drop_cnt} + drop_sum_s;
      drop_cnt_d = drop_tot_s[8] ? 8'hFF : drop_tot_s[7:0];
   end

   // Read-out register shows only entries already stored, giving the extra output stage.
   always_comb begin
      rd_next_s    = rd_ptr_q + AW'(pop_s);
      count_kept_s = count_q - (AW+1)'(pop_s);
      count_d      = count_kept_s + (AW+1)'(push_s);
      evt_valid_d  = (count_kept_s != '0);
      head_s       = evt_valid_d ? mem_q[rd_next_s] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            dbc_q[i] <= '0;
            pts_q[i] <= '0;
         end
         for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
         stable_q   <= '0;
         ts_q       <= '0;
         pend_q     <= '0;
         pdir_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         evt_valid  <= 1'b0;
         evt_bit    <= '0;
         evt_rising <= 1'b0;
         evt_ts     <= '0;
         ovf        <= 1'b0;
         drop_cnt   <= 8'd0;
      end else begin
         sync_q[0] <= gpio;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         stable_q <= stable_d;
         dbc_q    <= dbc_d;
         ts_q     <= ts_q + TS_W'(1);
         pend_q   <= pend_d;
         pdir_q   <= pdir_d;
         pts_q    <= pts_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_s;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_q <= wr_ptr_q;
         end
         rd_ptr_q  <= rd_next_s;
         count_q   <= count_d;
         evt_valid <= evt_valid_d;
         {evt_bit, evt_rising, evt_ts} <= head_s;
         if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
         end else if (|drop_s) begin
            ovf      <= 1'b1;
            drop_cnt <= drop_cnt_d;
         end else begin
            ovf      <= ovf;
            drop_cnt <= drop_cnt;
         end
      end
   end

endmodule
